// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source producing DrawX/DrawY, blank, hs/vs, frame strobe and frame counter
// Ports:
//   vga_clk     in  1   pixel clock, the only clock
//   reset_n     in  1   synchronous active-low reset
//   DrawX       out 10  horizontal position 0..H_TOTAL-1
//   DrawY       out 10  vertical position 0..V_TOTAL-1
//   blank       out 1   1 = visible pixel, 0 = blanking
//   hs          out 1   horizontal sync, active-low
//   vs          out 1   vertical sync, active-low
//   frame_start out 1   one-cycle pulse while position is (0,0)
//   frame_count out 16  completed frames, wraps
// Optional feature: define VGA_SYNC_ALIGN_EN to delay hs/vs by SYNC_DELAY clocks so they
// line up with consumers that register colour with that much latency.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
`ifdef VGA_SYNC_ALIGN_EN
    localparam int SYNC_STAGES = SYNC_DELAY;
`else
    localparam int SYNC_STAGES = 0;
`endif

    // run is low only for the first edge after reset, which presents (0,0)
    // without advancing and without counting a completed frame.
    logic       run;
    logic       x_last;
    logic       y_last;
    logic [9:0] nx;
    logic [9:0] ny;

    always_comb begin
        x_last = int'(DrawX) == H_TOTAL - 1;
        y_last = int'(DrawY) == V_TOTAL - 1;
        nx     = (!run || x_last) ? 10'd0 : DrawX + 10'd1;
        ny     = (!run || (x_last && y_last)) ? 10'd0 : x_last ? DrawY + 10'd1 : DrawY;
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            run         <= 1'b0;
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            run         <= 1'b1;
            DrawX       <= nx;
            DrawY       <= ny;
            blank       <= int'(nx) < H_ACTIVE && int'(ny) < V_ACTIVE;
            frame_start <= nx == 10'd0 && ny == 10'd0;
            if (run && x_last && y_last)
                frame_count <= frame_count + 16'd1;
        end
    end

    if (SYNC_STAGES == 0) begin : g_direct
        // Sync decoded from the next position so it registers alongside it.
        always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
                hs <= 1'b1;
                vs <= 1'b1;
            end else begin
                hs <= !(int'(nx) >= HS_BEG && int'(nx) < HS_END);
                vs <= !(int'(ny) >= VS_BEG && int'(ny) < VS_END);
            end
        end
    end else begin : g_align
        // Sync decoded from the presented position, then shifted SYNC_STAGES
        // times; the last stage is the output, giving exactly SYNC_STAGES
        // cycles between a coordinate and the sync edge it causes.
        logic [SYNC_STAGES-1:0] hs_pipe;
        logic [SYNC_STAGES-1:0] vs_pipe;
        always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
                hs_pipe <= '1;
                vs_pipe <= '1;
            end else begin
                hs_pipe <= (hs_pipe << 1) | SYNC_STAGES'(!(int'(DrawX) >= HS_BEG && int'(DrawX) < HS_END));
                vs_pipe <= (vs_pipe << 1) | SYNC_STAGES'(!(int'(DrawY) >= VS_BEG && int'(DrawY) < VS_END));
            end
        end
        assign hs = hs_pipe[SYNC_STAGES-1];
        assign vs = vs_pipe[SYNC_STAGES-1];
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen (default, small and 1x1 raster instances)
module tb_vga_timing_gen;
`ifdef VGA_SYNC_ALIGN_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    typedef struct {
        int x;
        int y;
        bit blank;
        bit hs;
        bit vs;
        bit fs;
        int fc;
    } exp_t;

    typedef struct {
        int t;
        int x;
        int y;
        bit blank;
        bit hs_d;
        bit hs_a;
        bit fs;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ra, rb, rc;
    logic [9:0] xa, ya, xb, yb, xc, yc;
    logic ba, ha, va, fa, bb, hb, vb, fb, bc, hc, vc, fc_s;
    logic [15:0] ca, cb, cc;

    vga_timing_gen u_a (
        .vga_clk(clk), .reset_n(ra), .DrawX(xa), .DrawY(ya), .blank(ba),
        .hs(ha), .vs(va), .frame_start(fa), .frame_count(ca)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_b (
        .vga_clk(clk), .reset_n(rb), .DrawX(xb), .DrawY(yb), .blank(bb),
        .hs(hb), .vs(vb), .frame_start(fb), .frame_count(cb)
    );

    vga_timing_gen #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
    ) u_c (
        .vga_clk(clk), .reset_n(rc), .DrawX(xc), .DrawY(yc), .blank(bc),
        .hs(hc), .vs(vc), .frame_start(fc_s), .frame_count(cc)
    );

    int n_chk = 0;
    int n_pass = 0;
    int ta = -1, tb = -1, tc = -1;
    bit mon_en = 0;

    // Cycles since reset release; -1 while reset was sampled low.
    always @(posedge clk) begin
        ta <= ra ? ta + 1 : -1;
        tb <= rb ? tb + 1 : -1;
        tc <= rc ? tc + 1 : -1;
    end

    // Reference: position is simply elapsed cycles folded by line and frame
    // length; sync comes from the position D cycles earlier.
    function automatic exp_t model(input int t, input int h_a, input int h_f, input int h_s, input int h_b,
                                   input int v_a, input int v_f, input int v_s, input int v_b);
        exp_t e;
        int ht, vt, ts, xs, ys;
        ht = h_a + h_f + h_s + h_b;
        vt = v_a + v_f + v_s + v_b;
        if (t < 0) return '{0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        e.x = t % ht;
        e.y = (t / ht) % vt;
        e.blank = e.x < h_a && e.y < v_a;
        e.fs = e.x == 0 && e.y == 0;
        e.fc = (t / (ht * vt)) % 65536;
        ts = t - D;
        if (ts < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            xs = ts % ht;
            ys = (ts / ht) % vt;
            e.hs = !(xs >= h_a + h_f && xs < h_a + h_f + h_s);
            e.vs = !(ys >= v_a + v_f && ys < v_a + v_f + v_s);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                       input logic b, input logic h, input logic v, input logic f, input logic [15:0] c);
        n_chk++;
        if (int'(x) == e.x && int'(y) == e.y && b === e.blank && h === e.hs && v === e.vs &&
            f === e.fs && int'(c) == e.fc)
            n_pass++;
        else
            $display("FAIL %s: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
                     nm, x, y, b, h, v, f, c, e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.fc);
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, want);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_a", model(ta, 640, 16, 96, 48, 480, 10, 2, 33), xa, ya, ba, ha, va, fa, ca);
            chk("mon_b", model(tb, 8, 2, 3, 2, 4, 1, 2, 1), xb, yb, bb, hb, vb, fb, cb);
            chk("mon_c", model(tc, 1, 0, 0, 0, 1, 0, 0, 0), xc, yc, bc, hc, vc, fc_s, cc);
        end
    end

    row_t rows [16];
    exp_t rst_e;
    exp_t org_e;

    initial begin
        int guard, n_fs, n_vs, n_hs;
        rows = '{
            '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{640,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{655,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{656,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{657,  657, 0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{658,  658, 0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{751,  751, 0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{752,  752, 0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{753,  753, 0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{754,  754, 0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{799,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{801,  1,   1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1439, 639, 1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1440, 640, 1, 1'b0, 1'b1, 1'b1, 1'b0}
        };
        rst_e = '{0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        org_e = '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        ra = 1'b0; rb = 1'b0; rc = 1'b0;
        @(posedge clk);
        mon_en = 1;
        repeat (5) begin
            @(negedge clk);
            chk("reset_a", rst_e, xa, ya, ba, ha, va, fa, ca);
        end
        ra = 1'b1; rb = 1'b1; rc = 1'b1;
        @(negedge clk);
        chk("first_a", org_e, xa, ya, ba, ha, va, fa, ca);

        foreach (rows[i]) begin
            guard = 0;
            while (ta < rows[i].t && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            chk($sformatf("row_t%0d", rows[i].t),
                '{rows[i].x, rows[i].y, rows[i].blank, (D == 0) ? rows[i].hs_d : rows[i].hs_a, 1'b1, rows[i].fs, 0},
                xa, ya, ba, ha, va, fa, ca);
        end

        while (ta < 1600) @(negedge clk);
        n_hs = 0;
        repeat (800) begin
            n_hs += int'(!ha);
            @(negedge clk);
        end
        chk_int("hs_low_per_line_a", n_hs, 96);

        guard = 0;
        while (fb !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk_int("wait_frame_start_b", int'(fb === 1'b1), 1);
        n_fs = 0; n_vs = 0; n_hs = 0;
        repeat (120) begin
            n_fs += int'(fb);
            n_vs += int'(!vb);
            n_hs += int'(!hb);
            @(negedge clk);
        end
        chk_int("fs_per_frame_b", n_fs, 1);
        chk_int("vs_low_per_frame_b", n_vs, 30);
        chk_int("hs_low_per_frame_b", n_hs, 24);

        guard = 0;
        while (!(xb == 10'd5 && yb == 10'd2) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk_int("reach_5_2_b", int'(xb == 10'd5 && yb == 10'd2), 1);
        rb = 1'b0;
        @(negedge clk);
        chk("midreset_b", rst_e, xb, yb, bb, hb, vb, fb, cb);
        rb = 1'b1;
        @(negedge clk);
        chk("restart_b", org_e, xb, yb, bb, hb, vb, fb, cb);

        repeat (250) begin
            repeat ($urandom_range(300, 1)) @(negedge clk);
            rb = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rb = 1'b1;
        end

        guard = 0;
        while (tc < 65535 && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        chk("wrap_ffff_c", '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 65535}, xc, yc, bc, hc, vc, fc_s, cc);
        @(negedge clk);
        chk("wrap_0000_c", '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0}, xc, yc, bc, hc, vc, fc_s, cc);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the video path. It generates the pixel coordinates `DrawX`/`DrawY` and the `blank` display-enable that the image and sprite readers consume on `vga_clk`. It also generates the `hs`/`vs` sync pulses for the DAC, a start-of-frame strobe and a frame counter for game-state logic. Default timing is 640x480@60 Hz on a 25 MHz `vga_clk`.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in clocks
- `H_SYNC`, 96: horizontal sync width, in clocks
- `H_BP`, 48: horizontal back porch, in clocks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `SYNC_DELAY`, 2: sync alignment depth in clocks; used only with `VGA_SYNC_ALIGN_EN`

Ports:
- `vga_clk` in 1: pixel clock; the only clock
- `reset_n` in 1: synchronous, active-low reset
- `DrawX` out 10: horizontal count, 0..H_TOTAL-1 (H_TOTAL = sum of the H params, 800)
- `DrawY` out 10: vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- `blank` out 1: 1 = visible pixel (`DrawX<H_ACTIVE && DrawY<V_ACTIVE`), 0 = blanking
- `hs` out 1: horizontal sync, active-low
- `vs` out 1: vertical sync, active-low
- `frame_start` out 1: one-cycle pulse while position is (0,0)
- `frame_count` out 16: count of completed frames, wraps

## Operation
- All outputs are registered. No combinational path runs from `reset_n` to any output.
- Reset values while `reset_n`=0 is sampled: `DrawX`=0, `DrawY`=0, `blank`=0, `hs`=1, `vs`=1, `frame_start`=0, `frame_count`=0. Every `SYNC_DELAY` stage also resets to 1.
- First edge with `reset_n`=1: outputs present position (0,0) with `blank`=1 and `frame_start`=1.
- On each later edge the position advances:
  - `DrawX` increments.
  - At `DrawX`=H_TOTAL-1 it wraps to 0 and `DrawY` increments.
  - At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- `frame_count` increments on the same edge that presents (0,0) after a completed frame. It wraps 0xFFFF→0x0000. It does not increment on the first (0,0) after reset.
- `hs`=0 exactly for `DrawX` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751] by default.
- `vs`=0 exactly for `DrawY` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491]. `vs` changes only at line boundaries, together with `DrawY`.
- `blank`, `DrawX`, `DrawY` and `frame_start` always describe the same position in the same cycle.
- Counter width: 10 bits. Totals above 1024 are unsupported. No error checking is done on parameters.
- Reset asserted mid-frame: on the next edge all outputs return to their reset values. Restart then proceeds as after power-up, and `frame_count` returns to 0.

## Timing
- Line period: H_TOTAL clocks (800). Frame period: H_TOTAL×V_TOTAL clocks (420000).
- `blank` goes 1→0 on the edge presenting `DrawX`=640. It goes 0→1 on the edge presenting `DrawX`=0 of rows 1..479.
- `frame_start` is high for exactly 1 cycle per frame.
- Consumers register color with 2 cycles of latency (ROM read plus output register). Sync alignment for that latency is covered under Configuration.

## Configuration
- Macro: `VGA_SYNC_ALIGN_EN`.
- Defined:
  - `hs` and `vs` each pass through a `SYNC_DELAY`-stage shift register.
  - Each sync edge appears `SYNC_DELAY` cycles after the coordinate that causes it. With the default of 2, `hs` falls on the edge presenting `DrawX`=658.
  - `DrawX`, `DrawY`, `blank` and `frame_start` are not delayed.
- Undefined:
  - No delay stages exist.
  - `hs`/`vs` align to the coordinates as described under Operation.

## Test plan
- Reset held 5 cycles, then released: during reset all outputs at reset values. First active edge gives (0,0), `blank`=1, `frame_start`=1, `frame_count`=0.
- Run one line: `blank` falls at `DrawX`=640. `hs`=0 for `DrawX` 656..751 (96 cycles). At `DrawX`=799 the next edge gives `DrawX`=0, `DrawY`=1.
- Run a full frame, 420000 cycles: `vs`=0 for `DrawY` 490..491 (1600 cycles). `frame_start` is seen exactly once. Wrap to (0,0) with `frame_count`=1.
- Run 65536 frames, or force the count near wrap: `frame_count` goes 0xFFFF→0x0000 at frame start.
- Assert `reset_n`=0 for 1 cycle at (300,200): next edge gives reset values, the following edge gives (0,0). `frame_count`=0.
- With `VGA_SYNC_ALIGN_EN`: `hs` falls at `DrawX`=658 and rises at 754. `vs` falls 2 cycles after `DrawY` becomes 490. `blank` timing is unchanged.
